mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 182 ++++++++++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: turns one load/store from execute into a single word-aligned bus request,
// stalling upstream until the bus answers or the BUSY watchdog expires.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid_inst,
  input  logic        ex_mem_rd_mem,
  input  logic        ex_mem_wr_mem,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_store_data,
  input  logic        mem2proc_ready,
  input  logic [31:0] mem2proc_data,
  output logic        proc2mem_req,
  output logic        proc2mem_we,
  output logic [31:0] proc2mem_addr,
  output logic [31:0] proc2mem_wdata,
  output logic [3:0]  proc2mem_be,
  output logic        mem_stall_out,
  output logic [31:0] mem_result_out,
  output logic        mem_result_valid,
  output logic        mem_misaligned_out
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      result_q, result_d;
  logic             valid_q, valid_d;
  logic             mis_q, mis_d;

  logic        access, misaligned, is_half, is_word;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  assign access     = ex_mem_valid_inst & (ex_mem_rd_mem | ex_mem_wr_mem);
  assign is_half    = (ex_mem_funct3[1:0] == 2'b01);
  assign is_word    = (ex_mem_funct3[1:0] == 2'b10);
  assign misaligned = (is_half & ex_mem_alu_result[0]) |
                      (is_word & (ex_mem_alu_result[1:0] != 2'b00));

  // Store lanes: replicate the narrow datum so whichever lane is enabled carries it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    req_be    = 4'b1111;
    req_wdata = ex_mem_store_data;
    if (ex_mem_wr_mem) begin
      case (ex_mem_funct3[1:0])
        2'b00: begin
          req_be    = 4'b0001 << ex_mem_alu_result[1:0];
          req_wdata = {4{ex_mem_store_data[7:0]}};
        end
        2'b01: begin
          req_be    = 4'b0011 << ex_mem_alu_result[1:0];
          req_wdata = {2{ex_mem_store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_byte = mem2proc_data[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? mem2proc_data[31:16] : mem2proc_data[15:0];
    case (funct3_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_value = {24'b0, ld_byte};
      3'b101:  ld_value = {16'b0, ld_half};
      default: ld_value = mem2proc_data;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    result_d = result_q;
    valid_d  = 1'b0;
    mis_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_mem_valid_inst) begin
          if (!access) begin
            result_d = ex_mem_alu_result;
            valid_d  = 1'b1;
          end else if (misaligned) begin
            result_d = '0;
            valid_d  = 1'b1;
            mis_d    = 1'b1;
          end else begin
            state_d  = BUSY;
            cnt_d    = '0;
            addr_d   = {ex_mem_alu_result[31:2], 2'b00};
            we_d     = ex_mem_wr_mem;
            wdata_d  = req_wdata;
            be_d     = req_be;
            funct3_d = ex_mem_funct3;
            off_d    = ex_mem_alu_result[1:0];
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem2proc_ready) begin
          state_d  = DONE;
          result_d = we_q ? '0 : ld_value;
          valid_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          // Watchdog: report a poisoned result flagged like a misaligned access.
          state_d  = DONE;
          result_d = 32'hbaad_beef;
          valid_d  = 1'b1;
          mis_d    = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too because their values are directly visible on ports.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= 4'b0000;
      funct3_q <= '0;
      off_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      mis_q    <= mis_d;
    end
  end

  assign proc2mem_req       = (state_q == BUSY);
  assign proc2mem_we        = we_q;
  assign proc2mem_addr      = addr_q;
  assign proc2mem_wdata     = wdata_q;
  assign proc2mem_be        = be_q;
  assign mem_stall_out      = (state_q == BUSY) | ((state_q == IDLE) & access & ~misaligned);
  assign mem_result_out     = result_q;
  assign mem_result_valid   = valid_q;
  assign mem_misaligned_out = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios then randomized instructions,
// compared against an arithmetic reference model of the load/store rules.
module tb_mem_stage;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid_inst, ex_mem_rd_mem, ex_mem_wr_mem;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] ex_mem_alu_result, ex_mem_store_data;
  logic        mem2proc_ready;
  logic [31:0] mem2proc_data;
  logic        proc2mem_req, proc2mem_we;
  logic [31:0] proc2mem_addr, proc2mem_wdata;
  logic [3:0]  proc2mem_be;
  logic        mem_stall_out;
  logic [31:0] mem_result_out;
  logic        mem_result_valid, mem_misaligned_out;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk                (clk),
    .rst                (rst),
    .ex_mem_valid_inst  (ex_mem_valid_inst),
    .ex_mem_rd_mem      (ex_mem_rd_mem),
    .ex_mem_wr_mem      (ex_mem_wr_mem),
    .ex_mem_funct3      (ex_mem_funct3),
    .ex_mem_alu_result  (ex_mem_alu_result),
    .ex_mem_store_data  (ex_mem_store_data),
    .mem2proc_ready     (mem2proc_ready),
    .mem2proc_data      (mem2proc_data),
    .proc2mem_req       (proc2mem_req),
    .proc2mem_we        (proc2mem_we),
    .proc2mem_addr      (proc2mem_addr),
    .proc2mem_wdata     (proc2mem_wdata),
    .proc2mem_be        (proc2mem_be),
    .mem_stall_out      (mem_stall_out),
    .mem_result_out     (mem_result_out),
    .mem_result_valid   (mem_result_valid),
    .mem_misaligned_out (mem_misaligned_out)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_result = '0;
  logic        exp_mis = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int unsigned     sz;
    longint unsigned v;
    sz = size_of(f3);
    if (sz == 4) return word;
    v = (64'(word) >> (8 * (addr % 4))) & ((64'd1 << (8 * sz)) - 1);
    if (!f3[2] && v >= (64'd1 << (8 * sz - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input bit is_store, input logic [2:0] f3,
                                          input logic [31:0] addr);
    int unsigned mask;
    if (!is_store) return 4'hF;
    mask = ((32'd1 << size_of(f3)) - 1) << (addr % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (size_of(f3))
      1:       return 32'(d[7:0]) * 32'h0101_0101;
      2:       return 32'(d[15:0]) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Advance to the next negedge and check whatever result the previous cycle promised.
  task automatic next_cycle();
    @(negedge clk);
    check("result_valid", mem_result_valid, exp_valid);
    if (exp_valid) begin
      check("result", mem_result_out, exp_result);
      check("misaligned", mem_misaligned_out, exp_mis);
    end
    exp_valid = 1'b0;
  endtask

  // Present one instruction at the current negedge. lat = BUSY cycle carrying ready (0 = never).
  task automatic issue(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input int lat, input logic [31:0] rdata);
    bit acc, mis, answered;
    int n_busy;
    acc = v && (rd || wr);
    mis = acc && is_misaligned(f3, addr);
    ex_mem_valid_inst = v;
    ex_mem_rd_mem     = rd;
    ex_mem_wr_mem     = wr;
    ex_mem_funct3     = f3;
    ex_mem_alu_result = addr;
    ex_mem_store_data = sdata;
    mem2proc_ready    = 1'($urandom);
    mem2proc_data     = $urandom;
    #1;
    check("stall_idle", mem_stall_out, acc && !mis);
    check("req_idle", proc2mem_req, 1'b0);
    if (!acc) begin
      exp_valid  = v;
      exp_result = addr;
      exp_mis    = 1'b0;
    end else if (mis) begin
      exp_valid  = 1'b1;
      exp_result = '0;
      exp_mis    = 1'b1;
    end else begin
      answered = (lat >= 1) && (lat <= int'(TMO));
      n_busy   = answered ? lat : int'(TMO);
      for (int n = 1; n <= n_busy; n++) begin
        next_cycle();
        mem2proc_ready = (n == lat);
        mem2proc_data  = (n == lat) ? rdata : $urandom;
        #1;
        check("req_busy", proc2mem_req, 1'b1);
        check("stall_busy", mem_stall_out, 1'b1);
        check("we", proc2mem_we, wr);
        check("addr", proc2mem_addr, addr & ~32'h3);
        check("be", proc2mem_be, model_be(wr, f3, addr));
        if (wr) check("wdata", proc2mem_wdata, model_wdata(f3, sdata));
      end
      exp_valid  = 1'b1;
      exp_mis    = !answered;
      exp_result = !answered ? 32'hbaad_beef : (wr ? 32'h0 : model_load(f3, addr, rdata));
      next_cycle();
      mem2proc_ready = 1'($urandom);
      mem2proc_data  = $urandom;
      #1;
      check("stall_done", mem_stall_out, 1'b0);
      check("req_done", proc2mem_req, 1'b0);
    end
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    int         kind;
    bit         rd, wr;
    logic [2:0] f3;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    rst               = 1'b1;
    ex_mem_valid_inst = 1'b0;
    ex_mem_rd_mem     = 1'b0;
    ex_mem_wr_mem     = 1'b0;
    ex_mem_funct3     = '0;
    ex_mem_alu_result = '0;
    ex_mem_store_data = '0;
    mem2proc_ready    = 1'b0;
    mem2proc_data     = '0;
    repeat (2) @(negedge clk);
    check("rst_req", proc2mem_req, 1'b0);
    check("rst_we", proc2mem_we, 1'b0);
    check("rst_addr", proc2mem_addr, 32'h0);
    check("rst_wdata", proc2mem_wdata, 32'h0);
    check("rst_be", proc2mem_be, 4'b0000);
    check("rst_result", mem_result_out, 32'h0);
    check("rst_valid", mem_result_valid, 1'b0);
    check("rst_mis", mem_misaligned_out, 1'b0);
    check("rst_stall", mem_stall_out, 1'b0);
    rst = 1'b0;

    // LB 0x103, ready on the third BUSY cycle: four stall cycles, sign-extended 0x80.
    next_cycle(); issue(1, 1, 0, 3'b000, 32'h103, 32'h0, 3, 32'h80FF_FF00);
    // SH 0x1234 to 0x202, immediate ready: upper half-word lanes.
    next_cycle(); issue(1, 0, 1, 3'b001, 32'h202, 32'h0000_1234, 1, $urandom);
    // LW 0x101: misaligned, no request, no stall.
    next_cycle(); issue(1, 1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0);
    // ALU pass-through.
    next_cycle(); issue(1, 0, 0, 3'b000, 32'h0000_0042, 32'h0, 1, 32'h0);
    // LW that is never answered: watchdog.
    next_cycle(); issue(1, 1, 0, 3'b010, 32'h400, 32'h0, 0, 32'h0);

    // Reset in the second BUSY cycle aborts the access; a late ready is ignored.
    next_cycle();
    ex_mem_valid_inst = 1'b1;
    ex_mem_rd_mem     = 1'b1;
    ex_mem_wr_mem     = 1'b0;
    ex_mem_funct3     = 3'b010;
    ex_mem_alu_result = 32'h500;
    mem2proc_ready    = 1'b0;
    #1 check("abort_stall", mem_stall_out, 1'b1);
    next_cycle();
    #1 check("abort_busy1", proc2mem_req, 1'b1);
    next_cycle();
    rst = 1'b1;
    #1 check("abort_busy2", proc2mem_req, 1'b1);
    @(negedge clk);
    check("abort_req", proc2mem_req, 1'b0);
    check("abort_valid", mem_result_valid, 1'b0);
    check("abort_be", proc2mem_be, 4'b0000);
    rst               = 1'b0;
    ex_mem_valid_inst = 1'b0;
    mem2proc_ready    = 1'b1;
    mem2proc_data     = 32'hDEAD_0000;
    @(negedge clk);
    check("late_ready_req", proc2mem_req, 1'b0);
    check("late_ready_valid", mem_result_valid, 1'b0);
    mem2proc_ready = 1'b0;

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      rd   = 1'b0;
      wr   = 1'b0;
      f3   = ld_f3[$urandom_range(0, 4)];
      if (kind == 0) begin
        rd = 1'($urandom);
        wr = !rd;
      end else if (kind >= 3) begin
        wr = 1'($urandom);
        rd = !wr;
        if (wr) f3 = 3'($urandom_range(0, 2));
      end
      next_cycle();
      issue(kind != 0, rd, wr, f3, $urandom, $urandom, $urandom_range(1, TMO + 2), $urandom);
    end
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
